// File: rtl/breath_sequencer_pkg.sv
// Shared types and derived constants for the breathing-LED sequencer.
package breath_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RAMP_UP   = 2'd1,
        RAMP_DOWN = 2'd2
    } state_t;

    localparam logic [1:0] MODE_PINGPONG = 2'd0;
    localparam logic [1:0] MODE_CIRCULAR = 2'd1;
    localparam logic [1:0] MODE_ALL      = 2'd2;

    function automatic logic [31:0] calc_period(input int unsigned clock_frq,
                                                input int unsigned pwm_frq);
        return 32'(clock_frq / pwm_frq);
    endfunction

    function automatic logic [31:0] calc_step(input logic [31:0] period,
                                              input int unsigned steps);
        return period / 32'(steps);
    endfunction

endpackage

// File: rtl/breath_sequencer_if.sv
// Control/status bundle between the sequencer and whoever starts and observes it.
interface breath_sequencer_if #(
    parameter int unsigned LED_NUM = 4
);
    logic               START;
    logic               STOP;
    logic [1:0]         MODE;
    logic [7:0]         REPEAT;
    logic               BUSY;
    logic               DONE;
    logic               PWM_SYNC;
    logic [31:0]        COMPARE_VALUE;
    logic [LED_NUM-1:0] LED_SEL;
    logic [LED_NUM-1:0] LED;

    modport master (
        output START, STOP, MODE, REPEAT,
        input  BUSY, DONE, PWM_SYNC, COMPARE_VALUE, LED_SEL, LED
    );

    modport slave (
        input  START, STOP, MODE, REPEAT,
        output BUSY, DONE, PWM_SYNC, COMPARE_VALUE, LED_SEL, LED
    );
endinterface

// File: rtl/breath_sequencer_pwm_core.sv
// Shared PWM period counter, wrap pulse and registered, channel-gated LED outputs.
module breath_pwm_core #(
    parameter int unsigned LED_NUM    = 4,
    parameter logic [31:0] PWM_PERIOD = 32'd10
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               run,
    input  logic [31:0]        compare,
    input  logic [LED_NUM-1:0] led_sel,
    output logic               wrap,
    output logic [LED_NUM-1:0] led
);
    logic [31:0] cnt;

    assign wrap = run && (cnt == PWM_PERIOD - 32'd1);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt <= '0;
            led <= '0;
        end else begin
            if (!run || wrap)
                cnt <= '0;
            else
                cnt <= cnt + 32'd1;
            // compare == PWM_PERIOD keeps the output on for the whole period
            led <= {LED_NUM{cnt < compare}} & led_sel;
        end
    end
endmodule

// File: rtl/breath_sequencer.sv
// Breath sequencer: ramps one shared PWM compare up and down and rotates it across LED channels.
//   state     | meaning
//   IDLE      | counter held, compare 0, waiting for START
//   RAMP_UP   | compare rises by STEP at each period wrap
//   RAMP_DOWN | compare falls by STEP at each wrap; reaching 0 ends the breath
module breath_sequencer
    import breath_pkg::*;
#(
    parameter int unsigned CLOCK_FRQ = 50000000,
    parameter int unsigned PWM_FRQ   = 1000,
    parameter int unsigned STEPS     = 1000,
    parameter int unsigned LED_NUM   = 4
) (
    input  logic        CLK,
    input  logic        RST,
    breath_sequencer_if.slave bus
);
    localparam logic [31:0] PWM_PERIOD = calc_period(CLOCK_FRQ, PWM_FRQ);
    localparam logic [31:0] STEP       = calc_step(PWM_PERIOD, STEPS);
    localparam int          IDX_W      = $clog2(LED_NUM);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(LED_NUM - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

    state_t             state;
    logic               busy;
    logic               done;
    logic               stop_pending;
    logic               dir;
    logic [1:0]         mode_r;
    logic [7:0]         repeat_r;
    logic [7:0]         breath_cnt;
    logic [IDX_W-1:0]   idx;
    logic [LED_NUM-1:0] led_sel;
    logic [31:0]        compare;

    logic [31:0]        up_nxt;
    logic [31:0]        down_nxt;
    logic [IDX_W-1:0]   idx_nxt;
    logic               dir_nxt;
    logic               stop_now;
    logic               last_breath;
    logic               wrap;
    logic [LED_NUM-1:0] led;

    // Saturating ramp steps; written so neither side can wrap around 32 bits.
    always_comb begin
        up_nxt      = (compare >= PWM_PERIOD - STEP) ? PWM_PERIOD : compare + STEP;
        down_nxt    = (compare <= STEP) ? 32'd0 : compare - STEP;
        stop_now    = stop_pending | (bus.STOP & busy);
        last_breath = stop_now || ((repeat_r != 8'd0) && (breath_cnt + 8'd1 == repeat_r));
    end

    always_comb begin
        idx_nxt = idx;
        dir_nxt = dir;
        case (mode_r)
            MODE_CIRCULAR: idx_nxt = (idx == IDX_LAST) ? '0 : idx + IDX_ONE;
            MODE_ALL:      idx_nxt = idx;
            default: begin
                if (!dir) begin
                    if (idx == IDX_LAST) begin
                        idx_nxt = idx - IDX_ONE;
                        dir_nxt = 1'b1;
                    end else begin
                        idx_nxt = idx + IDX_ONE;
                    end
                end else begin
                    if (idx == '0) begin
                        idx_nxt = idx + IDX_ONE;
                        dir_nxt = 1'b0;
                    end else begin
                        idx_nxt = idx - IDX_ONE;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state        <= IDLE;
            busy         <= 1'b0;
            done         <= 1'b0;
            stop_pending <= 1'b0;
            dir          <= 1'b0;
            mode_r       <= '0;
            repeat_r     <= '0;
            breath_cnt   <= '0;
            idx          <= '0;
            led_sel      <= '0;
            compare      <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.START) begin
                        mode_r       <= (bus.MODE == 2'd3) ? MODE_PINGPONG : bus.MODE;
                        repeat_r     <= bus.REPEAT;
                        breath_cnt   <= '0;
                        idx          <= '0;
                        dir          <= 1'b0;
                        stop_pending <= 1'b0;
                        compare      <= '0;
                        busy         <= 1'b1;
                        led_sel      <= (bus.MODE == MODE_ALL) ? '1 : LED_NUM'(1);
                        state        <= RAMP_UP;
                    end
                end
                RAMP_UP: begin
                    if (bus.STOP)
                        stop_pending <= 1'b1;
                    if (wrap) begin
                        compare <= up_nxt;
                        // a stop turns the ramp around so brightness decays smoothly
                        if (up_nxt == PWM_PERIOD || stop_now)
                            state <= RAMP_DOWN;
                    end
                end
                RAMP_DOWN: begin
                    if (bus.STOP)
                        stop_pending <= 1'b1;
                    if (wrap) begin
                        compare <= down_nxt;
                        if (down_nxt == 32'd0) begin
                            breath_cnt <= breath_cnt + 8'd1;
                            if (last_breath) begin
                                state        <= IDLE;
                                busy         <= 1'b0;
                                done         <= 1'b1;
                                led_sel      <= '0;
                                stop_pending <= 1'b0;
                            end else begin
                                idx     <= idx_nxt;
                                dir     <= dir_nxt;
                                led_sel <= (mode_r == MODE_ALL) ? '1 : (LED_NUM'(1) << idx_nxt);
                                state   <= RAMP_UP;
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    breath_pwm_core #(
        .LED_NUM    (LED_NUM),
        .PWM_PERIOD (PWM_PERIOD)
    ) u_pwm (
        .CLK     (CLK),
        .RST     (RST),
        .run     (state != IDLE),
        .compare (compare),
        .led_sel (led_sel),
        .wrap    (wrap),
        .led     (led)
    );

    assign bus.BUSY          = busy;
    assign bus.DONE          = done;
    assign bus.PWM_SYNC      = wrap;
    assign bus.COMPARE_VALUE = compare;
    assign bus.LED_SEL       = led_sel;
    assign bus.LED           = led;
endmodule

// File: tb/tb_breath_sequencer.sv
// Directed bench for breath_sequencer: PWM_PERIOD=10, STEP=2, four channels.
module tb_breath_sequencer;
    logic CLK;
    logic RST;
    int   errors = 0;
    int   checks = 0;

    breath_sequencer_if #(.LED_NUM(4)) bus ();

    breath_sequencer #(
        .CLOCK_FRQ (1000),
        .PWM_FRQ   (100),
        .STEPS     (5),
        .LED_NUM   (4)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic [31:0] cmp_log  [0:1023];
    logic [3:0]  sel_log  [0:1023];
    logic [3:0]  led_log  [0:1023];
    logic        busy_log [0:1023];
    logic        done_log [0:1023];
    logic        sync_log [0:1023];

    int exp_breath [10] = '{0, 2, 4, 6, 8, 10, 8, 6, 4, 2};
    int exp_stop   [9]  = '{0, 2, 4, 6, 8, 6, 4, 2, 0};
    int exp_pp     [8]  = '{0, 1, 2, 3, 2, 1, 0, 1};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Leaves the bench 1 time unit after the edge that accepts the START.
    task automatic pulse_start(input logic [1:0] mode, input logic [7:0] rep, input logic stop);
        bus.START  = 1'b1;
        bus.MODE   = mode;
        bus.REPEAT = rep;
        bus.STOP   = stop;
        @(posedge CLK); #1;
        bus.START  = 1'b0;
        bus.STOP   = 1'b0;
    endtask

    // Log n cycles; cycle k is sampled 1 unit after edge k (edge 0 accepted the START).
    task automatic run(input int n, input int stop_a, input int stop_b, input int restart_at);
        for (int k = 0; k < n; k++) begin
            cmp_log[k]  = bus.COMPARE_VALUE;
            sel_log[k]  = bus.LED_SEL;
            led_log[k]  = bus.LED;
            busy_log[k] = bus.BUSY;
            done_log[k] = bus.DONE;
            sync_log[k] = bus.PWM_SYNC;
            bus.STOP  = (k == stop_a) || (k == stop_b);
            bus.START = (k == restart_at);
            if (k == restart_at) begin
                bus.MODE   = 2'd0;
                bus.REPEAT = 8'd1;
            end
            @(posedge CLK); #1;
        end
        bus.STOP  = 1'b0;
        bus.START = 1'b0;
    endtask

    function automatic int first_done(input int n);
        for (int k = 0; k < n; k++)
            if (done_log[k]) return k;
        return -1;
    endfunction

    function automatic int count_done(input int n);
        int c = 0;
        for (int k = 0; k < n; k++) c += int'(done_log[k]);
        return c;
    endfunction

    function automatic int count_busy(input int n);
        int c = 0;
        for (int k = 0; k < n; k++) c += int'(busy_log[k]);
        return c;
    endfunction

    function automatic int count_sync(input int n);
        int c = 0;
        for (int k = 0; k < n; k++) c += int'(sync_log[k]);
        return c;
    endfunction

    initial begin
        logic [3:0] one_hot;
        int c;
        int bad;

        RST = 1'b1;
        bus.START = 1'b0;
        bus.STOP = 1'b0;
        bus.MODE = 2'd0;
        bus.REPEAT = 8'd0;
        repeat (3) @(posedge CLK);
        #1;
        check("rst_busy", bus.BUSY, 0);
        check("rst_done", bus.DONE, 0);
        check("rst_compare", bus.COMPARE_VALUE, 0);
        check("rst_led_sel", bus.LED_SEL, 0);
        check("rst_led", bus.LED, 0);
        check("rst_sync", bus.PWM_SYNC, 0);
        #4 RST = 1'b0;
        @(posedge CLK); #1;

        // 1: circular, single breath
        pulse_start(2'd1, 8'd1, 1'b0);
        run(110, -1, -1, -1);
        for (int p = 0; p < 10; p++)
            check($sformatf("t1_cmp_p%0d", p), cmp_log[10*p+5], exp_breath[p]);
        check("t1_cmp_idle", cmp_log[105], 0);
        check("t1_sel", sel_log[50], 4'b0001);
        c = 0; bad = 0;
        for (int k = 0; k < 110; k++) begin
            c += int'(led_log[k][0]);
            bad += int'(led_log[k][3:1] != 3'b000);
        end
        check("t1_led0_high", c, 50);
        check("t1_led_others", bad, 0);
        check("t1_busy_cycles", count_busy(110), 100);
        check("t1_done_count", count_done(110), 1);
        check("t1_done_cycle", first_done(110), 100);
        check("t1_sync_count", count_sync(110), 10);
        check("t1_sel_end", sel_log[105], 0);

        // 2: ping-pong, eight breaths
        repeat (3) @(posedge CLK); #1;
        pulse_start(2'd0, 8'd8, 1'b0);
        run(820, -1, -1, -1);
        for (int b = 0; b < 8; b++) begin
            one_hot = 4'b0001;
            one_hot = one_hot << exp_pp[b];
            check($sformatf("t2_sel_b%0d", b), sel_log[100*b+50], one_hot);
        end
        check("t2_done_cycle", first_done(820), 800);
        check("t2_done_count", count_done(820), 1);
        bad = 0;
        for (int k = 801; k < 820; k++) bad += int'(led_log[k] != 4'b0000);
        check("t2_led_after", bad, 0);
        check("t2_sel_after", sel_log[810], 0);

        // 3: all-on, two breaths
        repeat (3) @(posedge CLK); #1;
        pulse_start(2'd2, 8'd2, 1'b0);
        run(210, -1, -1, -1);
        check("t3_sel", sel_log[50], 4'b1111);
        check("t3_sel_b2", sel_log[150], 4'b1111);
        c = 0; bad = 0;
        for (int k = 0; k < 210; k++) begin
            c += int'(led_log[k] == 4'b1111);
            bad += int'(led_log[k] != 4'b1111 && led_log[k] != 4'b0000);
        end
        check("t3_led_split", bad, 0);
        check("t3_led_on", c, 100);
        check("t3_done_cycle", first_done(210), 200);

        // 4: endless circular, STOP while compare=6 ramping up, second STOP in ramp-down
        repeat (3) @(posedge CLK); #1;
        pulse_start(2'd1, 8'd0, 1'b0);
        run(300, 33, 55, -1);
        for (int p = 0; p < 9; p++)
            check($sformatf("t4_cmp_p%0d", p), cmp_log[10*p+5], exp_stop[p]);
        check("t4_done_cycle", first_done(300), 80);
        check("t4_done_count", count_done(300), 1);
        check("t4_busy_cycles", count_busy(300), 80);

        // 5: START+STOP together, then an ignored START mid-breath
        repeat (3) @(posedge CLK); #1;
        pulse_start(2'd1, 8'd2, 1'b1);
        check("t5_busy", bus.BUSY, 1);
        run(210, -1, -1, 25);
        for (int p = 0; p < 20; p++)
            check($sformatf("t5_cmp_p%0d", p), cmp_log[10*p+5], exp_breath[p % 10]);
        check("t5_sel_b2", sel_log[150], 4'b0010);
        check("t5_done_cycle", first_done(210), 200);

        // 6: asynchronous reset mid ramp-down
        repeat (3) @(posedge CLK); #1;
        pulse_start(2'd1, 8'd0, 1'b0);
        run(75, -1, -1, -1);
        check("t6_pre_cmp", bus.COMPARE_VALUE, 6);
        #3 RST = 1'b1;
        #1;
        check("t6_busy", bus.BUSY, 0);
        check("t6_led", bus.LED, 0);
        check("t6_cmp", bus.COMPARE_VALUE, 0);
        check("t6_sel", bus.LED_SEL, 0);
        #2 RST = 1'b0;
        run(30, -1, -1, -1);
        check("t6_idle_busy", count_busy(30), 0);
        check("t6_idle_sync", count_sync(30), 0);
        c = 0;
        for (int k = 0; k < 30; k++) c += int'(cmp_log[k] != 0);
        check("t6_idle_cmp", c, 0);
        pulse_start(2'd1, 8'd1, 1'b0);
        run(20, -1, -1, -1);
        check("t6_restart_busy", busy_log[0], 1);
        check("t6_restart_cmp", cmp_log[15], 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/breath_sequencer.md
Name: breath_sequencer

Overview:
Controller for the shared breathing-LED PWM engine. It owns one PWM period counter and one compare value, and time-shares them across LED_NUM LED channels. It ramps duty up and then down once per breath, and picks the next channel according to a pattern mode. Software or top-level logic starts and stops it with pulses and can request a finite number of breaths.

Parameters:
CLOCK_FRQ, 50000000, input clock frequency in Hz
PWM_FRQ, 1000, PWM carrier frequency in Hz; PWM_PERIOD = CLOCK_FRQ/PWM_FRQ cycles
STEPS, 1000, duty updates per half-breath; STEP = PWM_PERIOD/STEPS (must be >= 1)
LED_NUM, 4, number of LED channels (2..8)

Ports:
CLK  in  1  system clock
RST  in  1  asynchronous, active-high reset
START  in  1  one-cycle start pulse; ignored while BUSY
STOP  in  1  one-cycle stop pulse; ignored while idle
MODE  in  2  pattern, sampled on accepted START: 0 ping-pong, 1 circular, 2 all-on, 3 treated as 0
REPEAT  in  8  breaths to run, sampled on accepted START; 0 = run until STOP
BUSY  out  1  high from the cycle after an accepted START until the end of sequence
DONE  out  1  one-cycle pulse at end of sequence
PWM_SYNC  out  1  one-cycle pulse on the last cycle of each PWM period
COMPARE_VALUE  out  32  current duty compare value, 0..PWM_PERIOD
LED_SEL  out  LED_NUM  one-hot active channel; all ones in mode 2
LED  out  LED_NUM  PWM outputs, registered

Behaviour:
- Interface: one clock CLK; RST is asynchronous and active-high. RST forces state IDLE and sets every output and internal register to 0 immediately, including mid-breath.
- States: IDLE, RAMP_UP, RAMP_DOWN.
- IDLE: PWM counter is held at 0 and COMPARE_VALUE is 0.
- START in IDLE: sample MODE and REPEAT, clear the breath count, set channel index to 0. Next cycle: state RAMP_UP, BUSY=1, counter=0, compare=0.
- START and STOP in the same IDLE cycle: START is accepted and STOP is ignored.
- PWM counter: runs 0..PWM_PERIOD-1 and wraps while not IDLE. PWM_SYNC=1 when counter==PWM_PERIOD-1.
- PWM bit: pwm = (counter < compare). LED <= {LED_NUM{pwm}} & LED_SEL, giving one cycle of latency. compare==PWM_PERIOD gives 100% on; compare==0 gives fully off.
- Compare updates happen only at a wrap, so duty is constant within a period.
  - RAMP_UP: nxt = min(compare+STEP, PWM_PERIOD). If nxt==PWM_PERIOD, go to RAMP_DOWN.
  - RAMP_DOWN: nxt = (compare<=STEP) ? 0 : compare-STEP. If nxt==0, the breath ends.
- At breath end, increment the breath count (8-bit). End of sequence occurs if stop_pending, or if REPEAT!=0 and count+1==REPEAT.
  - End of sequence: go to IDLE; next cycle BUSY=0, DONE=1 for one cycle, LED_SEL=0.
  - Otherwise: advance the channel index and go to RAMP_UP with compare 0.
- Channel index advance by mode:
  - Ping-pong: 0,1,..,LED_NUM-1,LED_NUM-2,..,1,0,1,... using a direction flag that reverses at both ends.
  - Circular: 0..LED_NUM-1 then wraps to 0.
  - All-on: index is unused; LED_SEL is all ones.
- STOP while BUSY sets stop_pending.
  - In RAMP_UP: at the next wrap, force RAMP_DOWN (compare still takes nxt). The ramp then decays normally to 0 before ending, so there is no brightness step.
  - In RAMP_DOWN: the current ramp completes.
  - Repeated STOP pulses have no extra effect.
- START while BUSY is ignored.
- Arithmetic is 32-bit unsigned; the saturation rules above prevent overflow and underflow. REPEAT=1 ends after exactly one breath.

Decomposition:
- Shared package breath_pkg holds:
  - the state enum (IDLE/RAMP_UP/RAMP_DOWN);
  - MODE encodings MODE_PINGPONG=0, MODE_CIRCULAR=1, MODE_ALL=2;
  - derived-constant functions for PWM_PERIOD and STEP.
- Natural sub-module: breath_pwm_core, containing the period counter, PWM_SYNC, compare comparison and registered LED gating. The sequencer FSM, ramp arithmetic and channel selection stay in the top level.

Test Plan:
Bench uses CLOCK_FRQ=1000, PWM_FRQ=100, STEPS=5, giving PWM_PERIOD=10 and STEP=2.
1. START, MODE=1, REPEAT=1 -> per-period compare 0,2,4,6,8,10,8,6,4,2. LED[0] high for exactly 50 of 100 cycles. DONE pulses once, 1 cycle after the 10th PWM_SYNC. BUSY high for exactly 100 cycles.
2. START, MODE=0, REPEAT=8, LED_NUM=4 -> LED_SEL one-hot index sequence 0,1,2,3,2,1,0,1; then DONE, and LED=0 afterwards.
3. START, MODE=2, REPEAT=2 -> LED_SEL=4'b1111 and all LED bits toggle identically; DONE after 200 cycles.
4. START, MODE=1, REPEAT=0; STOP while compare=6 in RAMP_UP -> compare 8 then RAMP_DOWN 6,4,2,0; DONE after decay; no further breaths.
5. START and STOP in the same idle cycle -> sequence starts (BUSY=1). A second START mid-breath is ignored: compare sequence is unchanged.
6. RST asserted mid-RAMP_DOWN (asynchronously, between edges) -> BUSY, LED, COMPARE_VALUE, LED_SEL go 0 immediately. After release, state is IDLE until the next START.
